// File: rtl/sig16b_to_double_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sig16b_to_double_pkg
// Brief    : Shared constants and FSM encoding for the sig16b -> double
//            converter.
// Revision : 1.0 - initial release
// ============================================================================
package sig16b_to_double_pkg;

  localparam int DOUBLE_BIAS  = 1023;
  localparam int DOUBLE_W     = 64;
  localparam int EXP_W        = 11;
  localparam int MANT_W       = 52;
  localparam int SIG16B_W     = 16;
  localparam int SIG16B_MAG_W = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sig16b_to_double.sv
`default_nettype none
// ============================================================================
// Module   : sig16b_to_double
// Brief    : Converts one 16-bit sign-magnitude sample per sampling period to
//            an IEEE-754 double. Normalisation shifts one bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sig16b_to_double
  import sig16b_to_double_pkg::*;
#(
  parameter logic [12:0] TRIGGER_COUNT = 13'd0
) (
  input  logic                clk_operation,
  input  logic                rst,
  input  logic                enable,
  input  logic [12:0]         sampling_cycle_counter,
  input  logic [SIG16B_W-1:0] sig16b,
  output logic [DOUBLE_W-1:0] double,
  output logic                busy,
  output logic                done
);

  state_t                  state;
  state_t                  state_next;
  logic                    sign;
  logic                    zero;
  logic [SIG16B_MAG_W-1:0] mag;
  logic [3:0]              exp;
  logic                    trigger;
  logic                    in_zero;
  logic [EXP_W-1:0]        biased_exp;

  assign trigger    = enable && (state == IDLE) && (sampling_cycle_counter == TRIGGER_COUNT);
  assign in_zero    = (sig16b[SIG16B_MAG_W-1:0] == '0);
  // exp never exceeds 14, so the biased exponent cannot overflow 11 bits.
  assign biased_exp = EXP_W'(DOUBLE_BIAS) + EXP_W'(exp);

  // State register; asynchronous reset aborts any conversion in flight.
  always_ff @(posedge clk_operation or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; every transition is qualified by enable.
  always_comb begin
    state_next = state;
    if (enable) begin
      case (state)
        IDLE: if (trigger) state_next = in_zero ? PACK : NORM;
        NORM: if (mag[SIG16B_MAG_W-1]) state_next = PACK;
        PACK: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath: capture, shift-normalise, then pack into the output register.
  always_ff @(posedge clk_operation or posedge rst) begin
    if (rst) begin
      sign   <= 1'b0;
      zero   <= 1'b0;
      mag    <= '0;
      exp    <= 4'd0;
      double <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (enable) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            sign <= sig16b[SIG16B_W-1];
            mag  <= sig16b[SIG16B_MAG_W-1:0];
            zero <= in_zero;
            exp  <= 4'd14;
            busy <= 1'b1;
          end
        end
        NORM: begin
          if (!mag[SIG16B_MAG_W-1]) begin
            mag <= {mag[SIG16B_MAG_W-2:0], 1'b0};
            exp <= exp - 4'd1;
          end
        end
        PACK: begin
          // Zero magnitude, including negative zero, packs to +0.
          if (zero) begin
            double <= '0;
          end else begin
            double <= {sign, biased_exp, mag[SIG16B_MAG_W-2:0],
                       {(MANT_W-SIG16B_MAG_W+1){1'b0}}};
          end
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sig16b_to_double.sv
`default_nettype none
// ============================================================================
// Module   : tb_sig16b_to_double
// Brief    : Directed self-checking bench for sig16b_to_double, plus a strided
//            round-trip sweep through a behavioural double -> sig16b decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sig16b_to_double;
  import sig16b_to_double_pkg::*;

  localparam logic [12:0] TRIG = 13'd0;

  logic        clk_operation = 1'b0;
  logic        rst           = 1'b1;
  logic        enable        = 1'b1;
  logic [12:0] cnt           = 13'd7;
  logic [15:0] sig16b        = 16'h0;
  logic [63:0] dbl;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  sig16b_to_double #(.TRIGGER_COUNT(TRIG)) dut (
    .clk_operation          (clk_operation),
    .rst                    (rst),
    .enable                 (enable),
    .sampling_cycle_counter (cnt),
    .sig16b                 (sig16b),
    .double                 (dbl),
    .busy                   (busy),
    .done                   (done)
  );

  always #5 clk_operation = ~clk_operation;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inverse of the packing format: double back to sign-magnitude sig16b.
  function automatic logic [15:0] to_sig16b(input logic [63:0] d);
    int          e;
    logic [14:0] m;
    if (d[62:0] == 63'd0) return 16'h0000;
    e = int'(d[62:52]) - DOUBLE_BIAS;
    m = 15'({1'b1, d[51:38]} >> (14 - e));
    return {d[63], m};
  endfunction

  // Launch one conversion (edge T is the edge after the trigger setup) and
  // return the number of edges after T until done is seen. Optionally drops
  // enable for stall_len edges starting after edge T+stall_at.
  task automatic run_conv(input logic [15:0] v, input int stall_at, input int stall_len,
                          output int lat);
    @(posedge clk_operation); #1;
    cnt    = TRIG;
    sig16b = v;
    @(posedge clk_operation); #1;
    cnt    = 13'd7;
    sig16b = 16'h5A5A;
    check("busy_after_T", {63'd0, busy}, 64'd1);
    lat = 99;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk_operation); #1;
      if (done) begin
        lat = c;
        break;
      end
      if (stall_len > 0 && c == stall_at) enable = 1'b0;
      if (stall_len > 0 && c == stall_at + stall_len) enable = 1'b1;
    end
    enable = 1'b1;
  endtask

  task automatic directed(input string tag, input logic [15:0] v, input int exp_lat,
                          input logic [63:0] exp_d);
    int lat;
    run_conv(v, 0, 0, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_dbl"}, dbl, exp_d);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [63:0] held;
    logic [15:0] v;
    logic [15:0] want;
    int          k;

    repeat (3) @(posedge clk_operation);
    #1;
    check("rst_dbl", dbl, 64'h0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;

    // No trigger while the counter sits off the programmed phase.
    repeat (4) @(posedge clk_operation);
    #1;
    check("no_trig_busy", {63'd0, busy}, 64'd0);

    directed("p1",     16'h0001, 16, 64'h3FF0_0000_0000_0000);
    directed("p4000",  16'h4000, 2,  64'h40D0_0000_0000_0000);
    directed("p7fff",  16'h7FFF, 2,  64'h40DF_FFC0_0000_0000);
    directed("m3",     16'h8003, 15, 64'hC008_0000_0000_0000);
    directed("negz",   16'h8000, 1,  64'h0);
    directed("m1",     16'h8001, 16, 64'hBFF0_0000_0000_0000);
    directed("p5",     16'h0005, 14, 64'h4014_0000_0000_0000);

    // Stall for 5 edges while normalising.
    run_conv(16'h0001, 3, 5, lat);
    check("stall_lat", 64'(lat), 64'd21);
    check("stall_dbl", dbl, 64'h3FF0_0000_0000_0000);
    enable = 1'b0;
    repeat (2) @(posedge clk_operation);
    #1;
    check("hold_done", {63'd0, done}, 64'd1);
    check("hold_dbl", dbl, 64'h3FF0_0000_0000_0000);
    enable = 1'b1;
    @(posedge clk_operation); #1;
    check("done_clear", {63'd0, done}, 64'd0);
    check("dbl_stable", dbl, 64'h3FF0_0000_0000_0000);

    // Reset pulsed mid-conversion.
    @(posedge clk_operation); #1;
    cnt    = TRIG;
    sig16b = 16'h0001;
    @(posedge clk_operation); #1;
    cnt = 13'd7;
    repeat (4) @(posedge clk_operation);
    #1;
    rst = 1'b1;
    #1;
    check("arst_dbl", dbl, 64'h0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    @(posedge clk_operation); #1;
    rst  = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk_operation); #1;
      if (done || busy) seen++;
    end
    check("arst_quiet", 64'(seen), 64'd0);
    directed("p2", 16'h0002, 15, 64'h4000_0000_0000_0000);

    // Strided round-trip sweep with boundary values, latency derived from MSB.
    for (int i = -4; i < 65536; i += 97) begin
      case (i)
        -4: v = 16'h8000;
        -3: v = 16'hFFFF;
        -2: v = 16'h0000;
        -1: v = 16'h8001;
        default: v = 16'(i);
      endcase
      if (i >= 0 && i % 97 != 0) continue;
      k = 0;
      for (int b = 0; b < 15; b++) if (v[b]) k = 14 - b;
      run_conv(v, 0, 0, lat);
      want = (v == 16'h8000) ? 16'h0000 : v;
      check("rt_val", {48'd0, to_sig16b(dbl)}, {48'd0, want});
      check("rt_lat", 64'(lat), (v[14:0] == 15'd0) ? 64'd1 : 64'(k + 2));
      check("rt_low", {26'd0, dbl[37:0]}, 64'd0);
      if (i < 0) i = i - 96;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
